// File: rtl/lane_sum_accumulator.sv
// Eight-lane burst summer: a registered 3-stage adder tree feeds an accumulator.
// After BURST beats it publishes the sum and a rounded mean. Define LANE_SUM_MAX_TRACK_EN to add max_val.
module lane_sum_accumulator #(
   parameter int W     = 8,
   parameter int BURST = 32,
   parameter int SUM_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [W-1:0]               in0,
   input  logic [W-1:0]               in1,
   input  logic [W-1:0]               in2,
   input  logic [W-1:0]               in3,
   input  logic [W-1:0]               in4,
   input  logic [W-1:0]               in5,
   input  logic [W-1:0]               in6,
   input  logic [W-1:0]               in7,
   output logic                       busy,
   output logic [$clog2(BURST):0]     beat_cnt,
   output logic [SUM_W-1:0]           sum,
   output logic [W-1:0]               avg,
   output logic                       out_valid,
`ifdef LANE_SUM_MAX_TRACK_EN
   output logic [W-1:0]               max_val,
`endif
   output logic [1:0]                 state_dbg
);

   localparam int LOG2B = $clog2(BURST);
   localparam int CW    = LOG2B + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DRAIN = 2'd2} state_t;

   state_t state, state_next;

   logic [W:0]       s1 [4];
   logic [W+1:0]     s2 [2];
   logic [W+2:0]     s3;
   logic             s1_v, s2_v, s3_v;
   logic [SUM_W-1:0] acc;
   logic [SUM_W:0]   rnd;
   logic             accept, pipe_empty, done;

   // Handshake: a beat is taken on any posedge where in_valid=1 and busy=0.
   // There is no backpressure; beats offered while busy are simply lost.
   assign accept     = in_valid && (state != DRAIN);
   assign pipe_empty = !(s1_v || s2_v || s3_v);
   assign done       = (state == DRAIN) && pipe_empty;
   assign busy       = (state == DRAIN);
   assign state_dbg  = state;
   assign rnd        = {1'b0, acc} + (SUM_W+1)'(4 * BURST);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = ACCUM;
         ACCUM:   if (accept && beat_cnt == CW'(BURST - 1)) state_next = DRAIN;
         DRAIN:   if (pipe_empty) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      s1[0] <= {1'b0, in0} + {1'b0, in1};
      s1[1] <= {1'b0, in2} + {1'b0, in3};
      s1[2] <= {1'b0, in4} + {1'b0, in5};
      s1[3] <= {1'b0, in6} + {1'b0, in7};
      s2[0] <= {1'b0, s1[0]} + {1'b0, s1[1]};
      s2[1] <= {1'b0, s1[2]} + {1'b0, s1[3]};
      s3    <= {1'b0, s2[0]} + {1'b0, s2[1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v <= 1'b0;
         s2_v <= 1'b0;
         s3_v <= 1'b0;
      end else begin
         s1_v <= accept;
         s2_v <= s1_v;
         s3_v <= s2_v;
      end
   end

   // The drain ends once the last beat has left stage3, so done never overlaps an add.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc      <= '0;
         beat_cnt <= '0;
      end else if (done) begin
         acc      <= '0;
         beat_cnt <= '0;
      end else begin
         if (s3_v)   acc      <= acc + SUM_W'(s3);
         if (accept) beat_cnt <= beat_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum       <= '0;
         avg       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= done;
         if (done) begin
            sum <= acc;
            avg <= W'(rnd >> (LOG2B + 3));
         end
      end
   end

`ifdef LANE_SUM_MAX_TRACK_EN
   logic [W-1:0] lanes [8];
   logic [W-1:0] lane_max;
   logic [W-1:0] run_max;

   assign lanes[0] = in0;
   assign lanes[1] = in1;
   assign lanes[2] = in2;
   assign lanes[3] = in3;
   assign lanes[4] = in4;
   assign lanes[5] = in5;
   assign lanes[6] = in6;
   assign lanes[7] = in7;

   always_comb begin
      lane_max = lanes[0];
      for (int i = 1; i < 8; i++) begin
         if (lanes[i] > lane_max) lane_max = lanes[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_max <= '0;
         max_val <= '0;
      end else if (done) begin
         run_max <= '0;
         max_val <= run_max;
      end else if (accept && lane_max > run_max) begin
         run_max <= lane_max;
      end
   end
`endif

endmodule
